// File: rtl/spk_seq_pkg.sv
// Shared definitions for the spike layer sequencer.
//   state_t     : sequencer FSM states
//   SPK_LANES   : 2-bit lanes per AC spike word
//   SPK_LANE_W  : width of one lane
//   SPK_ADDR_W  : default SRAM word-address width
package spk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STREAM = 3'd2,
    WRITE  = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam int SPK_LANES  = 8;
  localparam int SPK_LANE_W = 2;
  localparam int SPK_ADDR_W = 9;

endpackage

// File: rtl/spk_layer_sequencer.sv
// Spike layer sequencer: walks cfg_len words of one layer pass, driving the
// cntrl_* address/lane/strobe side of the spike memory controller.
// Per word: one FETCH cycle (SRAM read latency), eight lane beats to the
// accumulator under a valid/ready handshake, one WRITE cycle with both
// write enables, then the next word.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start                      begin a pass (accepted only in IDLE)
//   cfg_base_in/out, cfg_len   pass configuration, latched on start
//   acc_ready                  accumulator accepts current beat
//   cntrl_*                    SRAM read/write addresses, lane select, enables
//   ac_valid/ac_first/ac_last  lane beat qualifiers
//   busy, done                 pass status
module spk_layer_sequencer
  import spk_seq_pkg::*;
#(
  parameter int ADDR_W = SPK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_in,
  input  logic [ADDR_W-1:0] cfg_base_out,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              acc_ready,
  output logic [ADDR_W-1:0] cntrl_spkblty_read_addr,
  output logic [ADDR_W-1:0] cntrl_ac_spk_read_addr,
  output logic [2:0]        cntrl_ac_spk_read_switch,
  output logic [ADDR_W-1:0] cntrl_spk_write_addr,
  output logic              cntrl_spk_write_we,
  output logic [ADDR_W-1:0] cntrl_spkblty_write_addr,
  output logic              cntrl_spkblty_write_we,
  output logic              ac_valid,
  output logic              ac_first,
  output logic              ac_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] LAST_BEAT = 3'(SPK_LANES - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_out_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [2:0]        beat_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] wr_addr_reg;

  logic beat_accept;
  logic last_word;

  assign beat_accept = (state_reg == STREAM) && acc_ready;
  assign last_word   = (idx_reg == len_reg - ADDR_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (cfg_len == '0) ? FIN : FETCH;
      FETCH:   state_next = STREAM;
      STREAM:  if (beat_accept && beat_reg == LAST_BEAT) state_next = WRITE;
      WRITE:   state_next = last_word ? FIN : FETCH;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      base_out_reg <= '0;
      len_reg      <= '0;
      idx_reg      <= '0;
      beat_reg     <= '0;
      rd_addr_reg  <= '0;
      wr_addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_out_reg <= cfg_base_out;
            len_reg      <= cfg_len;
            idx_reg      <= '0;
            beat_reg     <= '0;
            // Read address tracks base_in + idx incrementally, so base_in
            // itself never needs to be kept.
            rd_addr_reg  <= cfg_base_in;
          end
        end
        STREAM: begin
          if (beat_accept) begin
            // Wraps 7 -> 0, leaving the counter ready for the next word.
            beat_reg <= beat_reg + 3'd1;
            if (beat_reg == LAST_BEAT) wr_addr_reg <= base_out_reg + idx_reg;
          end
        end
        WRITE: begin
          if (!last_word) begin
            idx_reg     <= idx_reg + ADDR_W'(1);
            rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cntrl_spkblty_read_addr  = rd_addr_reg;
  assign cntrl_ac_spk_read_addr   = rd_addr_reg;
  assign cntrl_ac_spk_read_switch = beat_reg;
  assign cntrl_spk_write_addr     = wr_addr_reg;
  assign cntrl_spkblty_write_addr = wr_addr_reg;
  assign cntrl_spk_write_we       = (state_reg == WRITE);
  assign cntrl_spkblty_write_we   = (state_reg == WRITE);
  assign ac_valid                 = (state_reg == STREAM);
  assign ac_first                 = (state_reg == STREAM) && (beat_reg == 3'd0);
  assign ac_last                  = (state_reg == STREAM) && (beat_reg == LAST_BEAT);
  assign busy                     = (state_reg == FETCH) || (state_reg == STREAM) ||
                                    (state_reg == WRITE);
  assign done                     = (state_reg == FIN);

endmodule
